// File: rtl/puf_pkg.sv
// puf_pkg: shared definitions for the SRAM-PUF capture controller.
//   - Default widths and frame depth for the uprocessor-to-ram1 capture path.
//   - Controller state encoding.
package puf_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ADDR_W      = 6;
  localparam int DEF_DEPTH       = 64;
  localparam int DEF_TIMEOUT_CYC = 50000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2,
    ERROR   = 2'd3
  } state_e;

endpackage

// File: rtl/strobe_sync.sv
// strobe_sync: brings the asynchronous uprocessor byte strobe into clk.
//   clk          in  system clock
//   rst          in  synchronous active-high reset
//   strobe_async in  asynchronous byte strobe (one rising edge per byte)
//   din_async    in  byte from the uprocessor, stable around the strobe edge
//   stb          out one-cycle pulse per strobe rising edge
//   din_s        out byte delayed to line up with stb
module strobe_sync
  import puf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe_async,
  input  logic [DATA_W-1:0] din_async,
  output logic              stb,
  output logic [DATA_W-1:0] din_s
);

  logic              sync1_q;
  logic              sync2_q;
  logic              sync3_q;
  logic [DATA_W-1:0] din1_q;
  logic [DATA_W-1:0] din2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      din1_q  <= '0;
      din2_q  <= '0;
    end else begin
      sync1_q <= strobe_async;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      // Data takes the same two stages as the strobe, so din_s is the byte
      // that was on the pins when the edge was first sampled.
      din1_q  <= din_async;
      din2_q  <= din1_q;
    end
  end

  assign stb   = sync2_q & ~sync3_q;
  assign din_s = din2_q;

endmodule

// File: rtl/puf_capture_ctrl.sv
// puf_capture_ctrl: captures one frame of the SRAM-PUF dump into ram1 and
// shares the single RAM port with a readout requester.
//   clk, rst            system clock, synchronous active-high reset
//   uprocessor_din/clk  byte and asynchronous byte strobe from the uprocessor
//   arm                 1-cycle pulse, starts or restarts a frame capture
//   rd_req/rd_addr      readout request (held until granted) and address
//   rd_gnt              readout granted this cycle
//   rd_valid/rd_data    read data, one cycle after rd_gnt
//   ram_addr/data/wren  ram1 write/read port; ram_q is ram1 registered output
//   busy, done          capturing / full frame stored
//   err_timeout         frame aborted, strobe stream stalled mid-frame
//   overflow            strobe arrived after the frame was complete
//   byte_cnt            bytes written in the current frame (0..DEPTH)
module puf_capture_ctrl
  import puf_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] uprocessor_din,
  input  logic              uprocessor_clk,
  input  logic              arm,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              overflow,
  output logic [ADDR_W:0]   byte_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  logic              stb;
  logic [DATA_W-1:0] din_s;

  state_e            state_q;
  logic [ADDR_W:0]   byte_cnt_q;
  logic [TMR_W-1:0]  timer_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;
  logic              ram_wren_q;
  logic              rd_valid_q;
  logic              done_q;
  logic              err_q;
  logic              ovf_q;
  logic [ADDR_W-1:0] wr_ptr;

  strobe_sync #(.DATA_W(DATA_W)) u_strobe_sync (
    .clk          (clk),
    .rst          (rst),
    .strobe_async (uprocessor_clk),
    .din_async    (uprocessor_din),
    .stb          (stb),
    .din_s        (din_s)
  );

  // The write pointer is the low bits of the byte count; it never wraps
  // because no writes are issued once the count reaches DEPTH.
  assign wr_ptr = byte_cnt_q[ADDR_W-1:0];

  // A registered write owns the RAM port this cycle; reads are also held off
  // for the whole capture so the frame streams in undisturbed.
  assign rd_gnt = rd_req & ~ram_wren_q & (state_q != CAPTURE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      timer_q    <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ram_wren_q <= 1'b0;
      rd_valid_q <= rd_gnt;
      // Remember the granted read address so ram_addr holds it afterwards.
      if (rd_gnt) begin
        ram_addr_q <= rd_addr;
      end
      if (arm) begin
        // arm beats a coincident strobe: that byte is dropped.
        state_q    <= CAPTURE;
        byte_cnt_q <= '0;
        timer_q    <= '0;
        done_q     <= 1'b0;
        err_q      <= 1'b0;
        ovf_q      <= 1'b0;
      end else begin
        case (state_q)
          CAPTURE: begin
            if (stb) begin
              ram_wren_q <= 1'b1;
              ram_addr_q <= wr_ptr;
              ram_data_q <= din_s;
              byte_cnt_q <= byte_cnt_q + CNT_ONE;
              timer_q    <= '0;
              if (byte_cnt_q == CNT_LAST) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end else if (byte_cnt_q != '0) begin
              // Stall timer only runs once the first byte has landed.
              if (timer_q == TMR_LAST) begin
                state_q <= ERROR;
                err_q   <= 1'b1;
              end else begin
                timer_q <= timer_q + TMR_ONE;
              end
            end
          end
          DONE: begin
            if (stb) begin
              ovf_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign ram_addr    = rd_gnt ? rd_addr : ram_addr_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_valid_q ? ram_q : '0;
  assign busy        = (state_q == CAPTURE);
  assign done        = done_q;
  assign err_timeout = err_q;
  assign overflow    = ovf_q;
  assign byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_puf_capture_ctrl.sv
module tb_puf_capture_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 6;
  localparam int DEP = 64;
  localparam int TMO = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] uprocessor_din = '0;
  logic          uprocessor_clk = 1'b0;
  logic          arm = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q = '0;
  logic          busy;
  logic          done;
  logic          err_timeout;
  logic          overflow;
  logic [AW:0]   byte_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_coll   = 0;

  // Behavioural model of the frame: what the pins have delivered and where
  // each byte must end up.
  bit            m_cap  = 0;
  bit            m_done = 0;
  bit            m_ovf  = 0;
  int            m_cnt  = 0;
  logic [DW-1:0] m_mem [DEP];
  int            exp_a[$];
  int            exp_d[$];
  int            obs_a[$];
  int            obs_d[$];

  logic [DW-1:0] ram_mem [DEP];

  puf_capture_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .uprocessor_din(uprocessor_din), .uprocessor_clk(uprocessor_clk),
    .arm(arm), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .busy(busy), .done(done), .err_timeout(err_timeout), .overflow(overflow),
    .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  // ram1: 64x8, registered read.
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  always @(negedge clk) begin
    if (ram_wren === 1'b1) begin
      obs_a.push_back(int'(ram_addr));
      obs_d.push_back(int'(ram_data));
      $display("write addr=%0d data=0x%02h", ram_addr, ram_data);
    end
    if (ram_wren === 1'b1 && rd_gnt === 1'b1) n_coll++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_arm();
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
    m_cap = 1; m_done = 0; m_ovf = 0; m_cnt = 0;
    exp_a.delete(); exp_d.delete(); obs_a.delete(); obs_d.delete();
  endtask

  // One byte on the pins: data set up, strobe high 8 clk, low 9 clk.
  task automatic send_byte(input logic [DW-1:0] d);
    @(posedge clk); #1 uprocessor_din = d;
    repeat (2) @(posedge clk);
    #1 uprocessor_clk = 1'b1;
    if (m_cap) begin
      exp_a.push_back(m_cnt);
      exp_d.push_back(int'(d));
      m_mem[m_cnt] = d;
      m_cnt++;
      if (m_cnt == DEP) begin m_cap = 0; m_done = 1; end
    end else if (m_done) begin
      m_ovf = 1;
    end
    repeat (8) @(posedge clk);
    #1 uprocessor_clk = 1'b0;
    repeat (9) @(posedge clk);
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, "_nwr"}, obs_a.size(), exp_a.size());
    n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, obs_a[i], exp_a[i]);
      chk({tag, "_data"}, obs_d[i], exp_d[i]);
    end
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, busy, m_cap);
    chk({tag, "_done"}, done, m_done);
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_cnt"}, byte_cnt, m_cnt);
  endtask

  initial begin
    logic [AW-1:0] ra [16];
    bit            seen;

    for (int i = 0; i < DEP; i++) ram_mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
    chk("rst_err", err_timeout, 0);  chk("rst_ovf", overflow, 0);
    chk("rst_cnt", byte_cnt, 0);     chk("rst_wren", ram_wren, 0);
    chk("rst_gnt", rd_gnt, 0);       chk("rst_valid", rd_valid, 0);
    chk("rst_rdata", rd_data, 0);    chk("rst_raddr", ram_addr, 0);
    chk("rst_rdat", ram_data, 0);

    // Strobes while unarmed are ignored
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i));
    chk("idle_nwr", obs_a.size(), 0);
    check_status("idle");

    // Full frame, data equal to address
    do_arm();
    for (int i = 0; i < DEP; i++) send_byte(8'(i));
    check_writes("frame0");
    check_status("frame0");

    // Single read of address 5, then a streamed burst of random reads
    @(posedge clk); #1 rd_req = 1'b1; rd_addr = 6'd5;
    @(negedge clk); chk("rd5_gnt", rd_gnt, 1);
    for (int k = 0; k < 16; k++) begin
      ra[k] = AW'($urandom_range(0, DEP - 1));
      @(posedge clk); #1 rd_addr = ra[k];
      @(negedge clk);
      chk("rd_gnt", rd_gnt, 1);
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, (k == 0) ? 32'h5 : 32'(m_mem[ra[k-1]]));
      $display("read addr=%0d data=0x%02h", (k == 0) ? 5 : ra[k-1], rd_data);
    end
    @(posedge clk); #1 rd_req = 1'b0;
    @(negedge clk);
    chk("rd_last", rd_data, m_mem[ra[15]]);
    @(negedge clk); chk("rd_idle_valid", rd_valid, 0);

    // 65th strobe: overflow, no write
    send_byte(8'h77);
    check_writes("ovf");
    check_status("ovf");

    // Random frame; last byte's write collides with a held read request
    do_arm();
    for (int i = 0; i < DEP - 1; i++) send_byte(8'($urandom));
    #1 rd_req = 1'b1; rd_addr = 6'd7;
    @(negedge clk); chk("cap_nogrant", rd_gnt, 0);
    @(posedge clk); #1 uprocessor_din = 8'($urandom);
    repeat (2) @(posedge clk);
    #1 uprocessor_clk = 1'b1;
    exp_a.push_back(DEP - 1); exp_d.push_back(int'(uprocessor_din));
    m_mem[DEP-1] = uprocessor_din; m_cnt = DEP; m_cap = 0; m_done = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ram_wren === 1'b1) seen = 1;
    end
    chk("coll_wr_seen", seen, 1);
    chk("coll_gnt_lost", rd_gnt, 0);
    @(negedge clk);
    chk("coll_gnt_next", rd_gnt, 1);
    chk("coll_wren_next", ram_wren, 0);
    @(negedge clk);
    chk("coll_valid", rd_valid, 1);
    chk("coll_data", rd_data, m_mem[7]);
    #1 rd_req = 1'b0;
    repeat (6) @(posedge clk);
    #1 uprocessor_clk = 1'b0;
    repeat (6) @(posedge clk);
    check_writes("frame1");
    check_status("frame1");

    // Overflow in DONE, then arm races a strobe: arm wins, byte dropped
    send_byte(8'h55);
    check_status("ovf2");
    obs_a.delete(); obs_d.delete();
    @(posedge clk); #1 uprocessor_clk = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
    m_cap = 1; m_done = 0; m_ovf = 0; m_cnt = 0;
    exp_a.delete(); exp_d.delete();
    repeat (4) @(posedge clk);
    #1 uprocessor_clk = 1'b0;
    repeat (4) @(posedge clk);
    check_writes("race");
    check_status("race");

    // Timeout after 10 bytes
    do_arm();
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    repeat (TMO - 40) @(posedge clk);
    @(negedge clk);
    chk("tmo_early_err", err_timeout, 0);
    chk("tmo_early_busy", busy, 1);
    repeat (45) @(posedge clk);
    m_cap = 0;
    @(negedge clk);
    chk("tmo_err", err_timeout, 1);
    check_status("tmo");
    send_byte(8'h99);
    check_writes("tmo");
    do_arm();
    @(negedge clk);
    chk("tmo_clear", err_timeout, 0);
    chk("tmo_rearm_busy", busy, 1);

    // Reset mid-frame, then a full frame completes normally
    do_arm();
    for (int i = 0; i < 30; i++) send_byte(8'($urandom));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_cap = 0; m_done = 0; m_ovf = 0; m_cnt = 0;
    check_status("midrst");
    do_arm();
    for (int i = 0; i < DEP; i++) send_byte(8'($urandom));
    check_writes("frame2");
    check_status("frame2");

    chk("no_collision", n_coll, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
